// File: rtl/change_dispenser.sv
// change_dispenser: greedy 10/5/1 coin payout FSM with a hopper eject/ack handshake.
// Optional REQ timeout enabled by defining CHANGE_TIMEOUT_EN.
module change_dispenser #(
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] change,
  input  logic       change_valid,
  input  logic [2:0] empty,
  input  logic       coin_ack,
  input  logic       clear,
  output logic [2:0] eject,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [3:0] owed,
  output logic       overrun
);
  typedef enum logic [2:0] {IDLE, SELECT, REQ, RELEASE, DONE, FAULT} state_t;
  state_t state, state_d;
  logic [3:0] rem, rem_d, owed_d, coin;
  logic [2:0] eject_d, pick;
  logic busy_d, done_d, fault_d, tmo;
`ifdef CHANGE_TIMEOUT_EN
  logic [7:0] cnt, cnt_d;
  assign tmo = cnt == 8'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  // The held eject bit identifies the coin being paid out.
  assign coin = eject[2] ? 4'd10 : eject[1] ? 4'd5 : 4'd1;
  assign pick = (rem >= 4'd10 && !empty[2]) ? 3'b100 :
                (rem >= 4'd5 && !empty[1])  ? 3'b010 :
                (rem != 4'd0 && !empty[0])  ? 3'b001 : 3'b000;
  always_comb begin
    state_d = state;
    rem_d = rem;
    eject_d = 3'b000;
`ifdef CHANGE_TIMEOUT_EN
    cnt_d = 8'd0;
`endif
    case (state)
      IDLE: if (change_valid) begin
        state_d = (change != 4'd0) ? SELECT : DONE;
        rem_d = change;
      end
      SELECT: begin
        state_d = (rem == 4'd0) ? DONE : (pick != 3'b000) ? REQ : FAULT;
        eject_d = pick;
      end
      REQ: if (coin_ack) begin
        rem_d = rem - coin;
        state_d = RELEASE;
      end else if (tmo) begin
        state_d = FAULT;
      end else begin
        eject_d = eject;
`ifdef CHANGE_TIMEOUT_EN
        cnt_d = cnt + 8'd1;
`endif
      end
      RELEASE: if (!coin_ack) state_d = SELECT;
      DONE: state_d = IDLE;
      FAULT: if (clear) begin
        state_d = IDLE;
        rem_d = 4'd0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d inside {SELECT, REQ, RELEASE};
    done_d = state_d == DONE;
    fault_d = state_d == FAULT;
    owed_d = fault_d ? rem_d : 4'd0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rem <= 4'd0;
      eject <= 3'b000;
      busy <= 1'b0;
      done <= 1'b0;
      fault <= 1'b0;
      owed <= 4'd0;
      overrun <= 1'b0;
`ifdef CHANGE_TIMEOUT_EN
      cnt <= 8'd0;
`endif
    end else begin
      state <= state_d;
      rem <= rem_d;
      eject <= eject_d;
      busy <= busy_d;
      done <= done_d;
      fault <= fault_d;
      owed <= owed_d;
      overrun <= overrun | (change_valid && state != IDLE);
`ifdef CHANGE_TIMEOUT_EN
      cnt <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: table-driven payout vectors with an eject scoreboard, plus
// hand sequences for overrun, optional timeout and asynchronous reset.
module tb_change_dispenser;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] change = 4'd0;
  logic change_valid = 1'b0, coin_ack = 1'b0, clear = 1'b0;
  logic [2:0] empty = 3'b000;
  logic [2:0] eject;
  logic busy, done, fault, overrun;
  logic [3:0] owed;
  int cnt = 0, err = 0;
  logic [2:0] q[$];

  typedef struct {
    logic [3:0] change;
    logic [2:0] empty;
    int         n_ej;
    logic       fault;
    logic [3:0] owed;
  } vec_t;
  vec_t tab[8];

  change_dispenser #(.TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .change(change), .change_valid(change_valid),
    .empty(empty), .coin_ack(coin_ack), .clear(clear), .eject(eject),
    .busy(busy), .done(done), .fault(fault), .owed(owed), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cnt++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_eject(input string nm);
    int t = 0;
    while (eject == 3'b000 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_eject_seen"}, eject != 3'b000, 1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int r, t, n, t_first;
    bit fin;
    logic got_fault;
    logic [3:0] got_owed;
    logic [2:0] exp;
    string nm;
    nm = $sformatf("v%0d", idx);
    q.delete();
    r = v.change;
    while (r != 0) begin
      if (r >= 10 && !v.empty[2]) begin q.push_back(3'b100); r -= 10; end
      else if (r >= 5 && !v.empty[1]) begin q.push_back(3'b010); r -= 5; end
      else if (!v.empty[0]) begin q.push_back(3'b001); r -= 1; end
      else break;
    end
    empty = v.empty;
    @(negedge clk);
    change = v.change;
    change_valid = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    t = 1; n = 0; t_first = -1; fin = 0; got_fault = 0; got_owed = 0;
    if (v.change != 0) chk({nm, "_busy"}, busy, 1);
    while (!fin && t < 500) begin
      if (eject != 3'b000) begin
        if (t_first < 0) t_first = t;
        n++;
        exp = (q.size() != 0) ? q.pop_front() : 3'b000;
        chk({nm, "_eject"}, eject, exp);
        repeat (2) @(negedge clk);
        chk({nm, "_eject_hold"}, eject, exp);
        coin_ack = 1'b1;
        @(negedge clk);
        chk({nm, "_eject_clr"}, eject, 0);
        coin_ack = 1'b0;
      end
      if (done || fault) begin
        fin = 1;
        got_fault = fault;
        got_owed = owed;
      end else begin
        @(negedge clk);
        t++;
      end
    end
    chk({nm, "_finished"}, fin, 1);
    chk({nm, "_n_eject"}, n, v.n_ej);
    chk({nm, "_queue_left"}, q.size(), 0);
    if (v.n_ej != 0) chk({nm, "_latency"}, t_first, 2);
    chk({nm, "_fault"}, got_fault, v.fault);
    chk({nm, "_owed"}, got_owed, v.owed);
    if (got_fault) begin
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk({nm, "_clr_fault"}, fault, 0);
      chk({nm, "_clr_owed"}, owed, 0);
    end else begin
      @(negedge clk);
      chk({nm, "_done_1cyc"}, done, 0);
    end
  endtask

  initial begin
    int k;
    tab[0] = '{4'd15, 3'b000, 2, 1'b0, 4'd0};
    tab[1] = '{4'd15, 3'b100, 3, 1'b0, 4'd0};
    tab[2] = '{4'd7,  3'b010, 7, 1'b0, 4'd0};
    tab[3] = '{4'd6,  3'b001, 1, 1'b1, 4'd1};
    tab[4] = '{4'd0,  3'b000, 0, 1'b0, 4'd0};
    tab[5] = '{4'd13, 3'b000, 4, 1'b0, 4'd0};
    tab[6] = '{4'd9,  3'b111, 0, 1'b1, 4'd9};
    tab[7] = '{4'd11, 3'b011, 1, 1'b1, 4'd1};
    #12;
    chk("rst_eject", eject, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_owed", owed, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) run_vec(i, tab[i]);
    chk("no_overrun", overrun, 0);

    empty = 3'b000;
    @(negedge clk);
    change = 4'd10;
    change_valid = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    wait_eject("ovr");
    chk("ovr_eject", eject, 3'b100);
`ifdef CHANGE_TIMEOUT_EN
    k = 0;
    while (eject == 3'b100 && k < 100) begin
      change_valid = (k == 3);
      k++;
      @(negedge clk);
    end
    change_valid = 1'b0;
    chk("tmo_cycles", k, 20);
    chk("tmo_eject", eject, 0);
    chk("tmo_fault", fault, 1);
    chk("tmo_owed", owed, 10);
    chk("tmo_overrun", overrun, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("tmo_clr", fault, 0);
`else
    change_valid = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("ovr_overrun", overrun, 1);
    chk("ovr_hold", eject, 3'b100);
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    k = 0;
    while (!done && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ovr_done", done, 1);
`endif

    @(negedge clk);
    @(negedge clk);
    change = 4'd10;
    change_valid = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    wait_eject("ar");
    chk("ar_eject", eject, 3'b100);
    #2 rst = 1'b0;
    #1;
    chk("ar_eject0", eject, 0);
    chk("ar_busy0", busy, 0);
    chk("ar_overrun0", overrun, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("ar_idle", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", cnt, err);
    $finish;
  end
endmodule
